// File: rtl/sr04_bcd_display.sv
// sr04_bcd_display: samples the HC-SR04 distance word at a fixed refresh rate, converts it to
// 4-digit packed BCD with a sequential double-dabble engine and drives a multiplexed 4-digit
// 7-segment display with leading-zero blanking and a dash pattern for the timeout code.
//
// Ports:
//   clk   - 1 MHz system clock, rising edge
//   rstn  - synchronous reset, active-low
//   data  - distance in cm (0..1023)
//   seg   - segments {g,f,e,d,c,b,a}
//   an    - digit enables, an[0] = units .. an[3] = thousands
//   bcd   - last converted value {thou,hund,tens,units}
//   busy  - high while a conversion is in progress
module sr04_bcd_display #(
  parameter int unsigned REFRESH_US     = 250000,
  parameter int unsigned DIGIT_US       = 1000,
  parameter int unsigned ERR_CODE       = 999,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [9:0]  data,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [15:0] bcd,
  output logic        busy
);

  localparam int unsigned RW = $clog2(REFRESH_US);
  localparam int unsigned DW = (DIGIT_US > 1) ? $clog2(DIGIT_US) : 1;
  localparam logic [RW-1:0] RefreshMax = RW'(REFRESH_US - 1);
  localparam logic [DW-1:0] DigitMax   = DW'(DIGIT_US - 1);
  localparam logic [9:0]    ErrCode    = 10'(ERR_CODE);
  localparam logic [6:0]    SegOff     = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]    AnOff      = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] refresh_q, refresh_d;
  logic [25:0]   shreg_q, shreg_d;
  logic [3:0]    iter_q, iter_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [DW-1:0] digit_cnt_q, digit_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          shown_q, shown_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic          tick;
  logic [25:0]   adj;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    pat_low;
  logic [6:0]    seg_low;
  logic [3:0]    an_low;

  assign tick = (refresh_q == RefreshMax);

  // Conversion engine and refresh timing.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    iter_d    = iter_q;
    bcd_d     = bcd_q;
    busy_d    = busy_q;
    err_d     = err_q;
    shown_d   = shown_q;
    refresh_d = tick ? '0 : refresh_q + RW'(1);

    // Add-3 correction on every BCD nibble that would overflow past 9 when doubled.
    adj = shreg_q;
    for (int n = 0; n < 4; n++) begin
      if (adj[10 + 4 * n +: 4] >= 4'd5) begin
        adj[10 + 4 * n +: 4] = adj[10 + 4 * n +: 4] + 4'd3;
      end
    end

    case (state_q)
      StIdle: begin
        if (tick) begin
          shreg_d = {16'd0, data};
          err_d   = (data == ErrCode);
          busy_d  = 1'b1;
          iter_d  = 4'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        shreg_d = {adj[24:0], 1'b0};
        iter_d  = iter_q + 4'd1;
        if (iter_q == 4'd9) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d   = shreg_q[25:10];
        busy_d  = 1'b0;
        shown_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Digit scan and segment decode from the registered result only.
  always_comb begin
    digit_cnt_d = digit_cnt_q + DW'(1);
    idx_d       = idx_q;
    if (digit_cnt_q == DigitMax) begin
      digit_cnt_d = '0;
      idx_d       = idx_q + 2'd1;
    end

    nib = bcd_q[{idx_q, 2'b00} +: 4];

    case (idx_q)
      2'd3:    blank = (bcd_q[15:12] == 4'd0);
      2'd2:    blank = (bcd_q[15:8] == 8'd0);
      2'd1:    blank = (bcd_q[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase

    case (nib)
      4'd0:    pat_low = 7'b1000000;
      4'd1:    pat_low = 7'b1111001;
      4'd2:    pat_low = 7'b0100100;
      4'd3:    pat_low = 7'b0110000;
      4'd4:    pat_low = 7'b0011001;
      4'd5:    pat_low = 7'b0010010;
      4'd6:    pat_low = 7'b0000010;
      4'd7:    pat_low = 7'b1111000;
      4'd8:    pat_low = 7'b0000000;
      4'd9:    pat_low = 7'b0010000;
      default: pat_low = 7'b1111111;
    endcase

    if (!shown_q) begin
      seg_low = 7'b1111111;
    end else if (err_q) begin
      seg_low = 7'b0111111;
    end else if (blank) begin
      seg_low = 7'b1111111;
    end else begin
      seg_low = pat_low;
    end

    an_low = shown_q ? ~(4'b0001 << idx_q) : 4'b1111;

    seg_d = SEG_ACTIVE_LOW ? seg_low : ~seg_low;
    an_d  = SEG_ACTIVE_LOW ? an_low : ~an_low;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      refresh_q   <= '0;
      shreg_q     <= '0;
      iter_q      <= 4'd0;
      bcd_q       <= 16'd0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      digit_cnt_q <= '0;
      idx_q       <= 2'd0;
      shown_q     <= 1'b0;
      seg_q       <= SegOff;
      an_q        <= AnOff;
    end else begin
      state_q     <= state_d;
      refresh_q   <= refresh_d;
      shreg_q     <= shreg_d;
      iter_q      <= iter_d;
      bcd_q       <= bcd_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      digit_cnt_q <= digit_cnt_d;
      idx_q       <= idx_d;
      shown_q     <= shown_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign bcd  = bcd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_sr04_bcd_display.sv
// Self-checking bench for sr04_bcd_display with a fast refresh/scan configuration.
module tb_sr04_bcd_display;

  localparam int R   = 20;
  localparam int D   = 4;
  localparam int ERR = 999;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [9:0]  data = 10'd0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] bcd;
  logic        busy;

  int checks = 0;
  int errors = 0;

  sr04_bcd_display #(
    .REFRESH_US    (R),
    .DIGIT_US      (D),
    .ERR_CODE      (ERR),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .data(data),
    .seg (seg),
    .an  (an),
    .bcd (bcd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    int         val;
    logic [15:0] exp_bcd;
    logic [6:0]  exp_units;
    logic [6:0]  exp_thou;
  } vec_t;

  // Active-low digit patterns 0..9.
  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int pow10(input int i);
    case (i)
      0:       return 1;
      1:       return 10;
      2:       return 100;
      default: return 1000;
    endcase
  endfunction

  function automatic logic [15:0] model_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] model_seg(input int v, input int idx);
    if (v == ERR) return 7'b0111111;
    if (idx > 0 && v < pow10(idx)) return 7'b1111111;
    return pat[(v / pow10(idx)) % 10];
  endfunction

  // One full sample/convert cycle. after_rst releases reset instead of waiting for idle,
  // and then also checks the first-tick delay and that the display stays dark until DONE.
  task automatic conv(input int v, input bit toggle, input bit after_rst);
    int n;
    int bc;
    if (after_rst) begin
      data = 10'(v);
      rstn = 1'b1;
    end else begin
      n = 0;
      while (busy !== 1'b0 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (busy !== 1'b0) chk("busy_low_timeout", {31'd0, busy}, 32'd0);
      data = 10'(v);
    end
    n = 0;
    while (busy !== 1'b1 && n < 3 * R) begin
      @(negedge clk);
      n++;
      if (after_rst) chk("an_dark_before_tick", {28'd0, an}, 32'hF);
    end
    if (busy !== 1'b1) chk("busy_rise_timeout", {31'd0, busy}, 32'd1);
    if (after_rst) chk("first_tick_delay", n, R);
    bc = 1;
    while (busy === 1'b1 && bc < 30) begin
      if (toggle) data = 10'($urandom_range(0, 1023));
      @(negedge clk);
      if (busy === 1'b1) bc++;
      if (after_rst) chk("an_dark_during_conv", {28'd0, an}, 32'hF);
    end
    data = 10'(v);
    chk("busy_cycles", bc, 11);
    chk("bcd_value", {16'd0, bcd}, {16'd0, model_bcd(v)});
  endtask

  // Watch two full scan rounds starting the cycle after the result lands.
  task automatic check_display(input int v, input logic [6:0] units, input logic [6:0] thou);
    int cnt [4];
    int idx;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    @(negedge clk);
    for (int c = 0; c < 8 * D; c++) begin
      chk("an_onehot", $countones(~an), 1);
      idx = 0;
      for (int i = 0; i < 4; i++) begin
        if (an[i] == 1'b0) begin
          idx = i;
          cnt[i]++;
        end
      end
      chk("seg_digit", {25'd0, seg}, {25'd0, model_seg(v, idx)});
      if (idx == 0) chk("seg_units_table", {25'd0, seg}, {25'd0, units});
      if (idx == 3) chk("seg_thou_table", {25'd0, seg}, {25'd0, thou});
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) chk("scan_dwell", cnt[i], 2 * D);
  endtask

  vec_t tv [8];
  int   v;
  int   n;

  initial begin
    tv[0] = '{123,  16'h0123, 7'b0110000, 7'h7F};
    tv[1] = '{1023, 16'h1023, 7'b0110000, 7'b1111001};
    tv[2] = '{999,  16'h0999, 7'b0111111, 7'b0111111};
    tv[3] = '{45,   16'h0045, 7'b0010010, 7'h7F};
    tv[4] = '{0,    16'h0000, 7'b1000000, 7'h7F};
    tv[5] = '{500,  16'h0500, 7'b1000000, 7'h7F};
    tv[6] = '{7,    16'h0007, 7'b1111000, 7'h7F};
    tv[7] = '{1000, 16'h1000, 7'b1000000, 7'b1111001};

    // Reset held for 5 clocks.
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_bcd", {16'd0, bcd}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Table-driven vectors; the first one also covers the post-reset behaviour.
    for (int i = 0; i < 8; i++) begin
      conv(tv[i].val, 1'b0, i == 0);
      chk("bcd_table", {16'd0, bcd}, {16'd0, tv[i].exp_bcd});
      check_display(tv[i].val, tv[i].exp_units, tv[i].exp_thou);
    end

    // Reset during the 5th shift cycle aborts the conversion.
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    data = 10'd321;
    n = 0;
    while (busy !== 1'b1 && n < 3 * R) begin
      @(negedge clk);
      n++;
    end
    chk("abort_busy_seen", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_bcd", {16'd0, bcd}, 32'd0);
    chk("abort_an", {28'd0, an}, 32'hF);
    chk("abort_seg", {25'd0, seg}, 32'h7F);

    // Restart with data toggling during the shift phase.
    conv(654, 1'b1, 1'b1);
    check_display(654, model_seg(654, 0), model_seg(654, 3));

    // Randomized values against the arithmetic model.
    for (int k = 0; k < 15; k++) begin
      v = (k % 5 == 4) ? ERR : int'($urandom_range(0, 1023));
      conv(v, k[0], 1'b0);
      check_display(v, model_seg(v, 0), model_seg(v, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
